apple_shadow_write_queue: RTL and testbench
===========================================

Name: apple_shadow_write_queue

Overview:
- Buffered, parametrised successor to the direct bus-to-SDRAM shadow write path.
- Qualifies Apple II bus writes against a per-4KB-page shadow mask and an N-bank aux/fast-bank select.
- Queues qualified writes in a FIFO and coalesces same-word writes in the newest entry.
- Drains entries to an SDRAM client port through a valid/ready handshake, so SDRAM back-pressure never loses a bus write until the queue overflows.

Parameters:
- FIFO_DEPTH, 8, number of queue entries; power of two, minimum 2.
- BANK_BITS, 1, width of bank select; bank 0 = main, bank 1 = aux/E1, higher values = additional 64KB banks; minimum 1.
- SHADOW_PAGE_MASK, 16'h003D, bit p set = page p (addr[15:12]) is shadowed; default covers 0000-0FFF and 2000-5FFF.
- MEM_ADDR_WIDTH, 21, SDRAM word-address width.

Ports:
- clk_logic  in  1  logic clock.
- system_reset_n  in  1  asynchronous active-low reset.
- bus_wr_strobe_i  in  1  one-cycle pulse: a bus write's data is valid this cycle.
- bus_addr_i  in  16  bus address.
- bus_data_i  in  8  bus write data.
- bus_bank_i  in  BANK_BITS  resolved bank (aux_mem / m2b0 already folded in).
- bus_m2sel_n_i  in  1  low = motherboard memory select; writes with this high are ignored.
- shadow_all_i  in  1  1 = ignore SHADOW_PAGE_MASK and shadow all pages.
- mem_wr_o  out  1  write request valid.
- mem_addr_o  out  MEM_ADDR_WIDTH  word address.
- mem_data_o  out  32  write data, byte replicated per lane.
- mem_byte_en_o  out  4  lane enables.
- mem_ready_i  in  1  SDRAM accepts the request this cycle when mem_wr_o is high.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held in the queue, excluding the output register.
- overflow_o  out  1  sticky; set on any dropped write.
- drop_count_o  out  16  saturating count of dropped writes.

Behaviour:
- Qualify: accept = bus_wr_strobe_i && !bus_m2sel_n_i && (shadow_all_i || SHADOW_PAGE_MASK[bus_addr_i[15:12]]).
- Lane = {bus_addr_i[0], bus_bank_i[0]}.
- Word address = zero-extended {bus_bank_i[BANK_BITS-1:1], bus_addr_i[15:1]}. With BANK_BITS=1 this is {0, addr[15:1]}.
- Entry format: {word_addr, data[31:0], byte_en[4]}. A new write sets data lane = bus_data_i and byte_en = 1<<lane.
- Coalesce: if accept, level ≥ 1, and tail entry word_addr == new word_addr, then merge into the tail:
  - tail.byte_en |= 1<<lane;
  - tail lane byte is replaced;
  - level is unchanged.
  - Merging into the head in the same cycle it is popped is forbidden; in that case push a new entry instead.
- Output FSM, two states:
  - IDLE: mem_wr_o=0. If level ≥ 1, pop the head into the output register and go to ISSUE next cycle.
  - ISSUE: mem_wr_o=1; addr, data and byte_en are held stable.
    - On mem_ready_i with level ≥ 1: pop the next head into the output register and stay in ISSUE (back-to-back, one write per cycle).
    - On mem_ready_i with level = 0: go to IDLE.
    - Without mem_ready_i: hold.
- Output register contents are never merged or altered while presented.
- Latency, empty queue in IDLE: strobe in cycle N → entry visible in cycle N+1 → mem_wr_o high in cycle N+2.
- Full:
  - If level == FIFO_DEPTH, no merge is possible, and no pop occurs this cycle, the write is dropped: overflow_o←1, drop_count_o increments, saturating at 16'hFFFF.
  - A push and pop in the same cycle while full is accepted; level stays FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. Level never exceeds FIFO_DEPTH and never underflows.
- Reset (asynchronous, any time, including mid-ISSUE):
  - mem_wr_o=0, mem_addr_o=0, mem_data_o=0, mem_byte_en_o=0;
  - fifo_level_o=0, overflow_o=0, drop_count_o=0;
  - FSM=IDLE; queued and in-flight entries are discarded.
- overflow_o and drop_count_o clear only on reset.

Test Plan:
- Single write, defaults: strobe addr=16'h0401 data=8'hA5 bank=0, mem_ready_i=1. Required: mem_wr_o high exactly one cycle at N+2, addr=21'h000200, data=32'hA5A5A5A5, byte_en=4'b0100.
- Masking: writes to 16'h1000 and 16'h6000 with shadow_all_i=0, and to 16'h2000 with bus_m2sel_n_i=1. Required: no mem_wr_o. Repeat 16'h6000 with shadow_all_i=1. Required: one write, addr=21'h003000.
- Coalesce: mem_ready_i=0; write 16'h2000 bank0 data 8'h11, 16'h2000 bank1 data 8'h22, 16'h2001 bank0 data 8'h33. Required: first write is in ISSUE; second creates a queue entry; third merges (level=1). Then mem_ready_i=1. Required: second request addr=21'h001000, byte_en=4'b0110, data lanes 1 = 8'h22 and 2 = 8'h33.
- Back-pressure/overflow, FIFO_DEPTH=8: mem_ready_i=0; ten writes to distinct words. Required: 1 in output register, level=8, 1 dropped, overflow_o=1, drop_count_o=1. Then mem_ready_i=1. Required: 9 requests on 9 consecutive cycles in original order.
- Full with simultaneous pop: level=8, mem_ready_i=1 with a new distinct write in the same cycle. Required: no drop, level stays 8.
- Reset mid-operation: assert system_reset_n low while in ISSUE with level=5. Required: all outputs 0 immediately (asynchronous). After release: no stale request issued; a fresh write works per the first scenario.

Source files
------------

// File: rtl/apple_shadow_write_queue.sv
// Shadow write queue: qualifies Apple II bus writes, buffers and coalesces them
// in a FIFO, and drains them to an SDRAM client over a valid/ready handshake.
module apple_shadow_write_queue #(
  parameter int          FIFO_DEPTH       = 8,
  parameter int          BANK_BITS        = 1,
  parameter logic [15:0] SHADOW_PAGE_MASK = 16'h003D,
  parameter int          MEM_ADDR_WIDTH   = 21
) (
  input  logic                          clk_logic,
  input  logic                          system_reset_n,
  input  logic                          bus_wr_strobe_i,
  input  logic [15:0]                   bus_addr_i,
  input  logic [7:0]                    bus_data_i,
  input  logic [BANK_BITS-1:0]          bus_bank_i,
  input  logic                          bus_m2sel_n_i,
  input  logic                          shadow_all_i,
  output logic                          mem_wr_o,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [31:0]                   mem_data_o,
  output logic [3:0]                    mem_byte_en_o,
  input  logic                          mem_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [15:0]                   drop_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [31:0]               data;
    logic [3:0]                be;
  } entry_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t           state_q, state_d;
  entry_t           fifo_q [FIFO_DEPTH];
  entry_t           fifo_d [FIFO_DEPTH];
  entry_t           out_q, out_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_idx;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic                      accept, pop, merge, push, drop;
  logic [1:0]                lane;
  logic [BANK_BITS+14:0]     wa_full;
  logic [MEM_ADDR_WIDTH-1:0] word_addr;

  // Bank bit 0 picks the lane; upper bank bits extend the word address.
  assign wa_full   = {bus_bank_i >> 1, bus_addr_i[15:1]};
  assign word_addr = MEM_ADDR_WIDTH'(wa_full);
  assign lane      = {bus_addr_i[0], bus_bank_i[0]};
  assign accept    = bus_wr_strobe_i && !bus_m2sel_n_i &&
                     (shadow_all_i || SHADOW_PAGE_MASK[bus_addr_i[15:12]]);
  assign tail_idx  = wr_ptr_q - 1'b1;

  always_comb begin
    pop   = (level_q != '0) && ((state_q == S_IDLE) || mem_ready_i);
    // A lone entry being popped this cycle is already on its way out; never merge into it.
    merge = accept && (level_q != '0) && (fifo_q[tail_idx].addr == word_addr) &&
            !(pop && (level_q == LVL_W'(1)));
    push  = accept && !merge && ((level_q != FULL_LVL) || pop);
    drop  = accept && !merge && !push;
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (merge) begin
      fifo_d[tail_idx].be[lane]                = 1'b1;
      fifo_d[tail_idx].data[{lane, 3'b000} +: 8] = bus_data_i;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: word_addr, data: {4{bus_data_i}}, be: 4'b0001 << lane};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          out_d   = fifo_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready_i) begin
          if (pop) out_d = fifo_q[rd_ptr_q];
          else     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q    <= S_IDLE;
      out_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  assign mem_wr_o      = (state_q == S_ISSUE);
  assign mem_addr_o    = out_q.addr;
  assign mem_data_o    = out_q.data;
  assign mem_byte_en_o = out_q.be;
  assign fifo_level_o  = level_q;
  assign overflow_o    = overflow_q;
  assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_apple_shadow_write_queue.sv
// Self-checking bench for apple_shadow_write_queue: directed scenarios plus
// randomized bursts compared against a byte-image model of the shadow memory.
module tb_apple_shadow_write_queue;
  localparam logic [15:0] MASK = 16'h003D;

  logic        clk_logic = 0, system_reset_n = 0;
  logic        bus_wr_strobe_i = 0, bus_m2sel_n_i = 0, shadow_all_i = 0, mem_ready_i = 0;
  logic [15:0] bus_addr_i = 0;
  logic [7:0]  bus_data_i = 0;
  logic [0:0]  bus_bank_i = 0;
  logic        mem_wr_o, overflow_o;
  logic [20:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_byte_en_o, fifo_level_o;
  logic [15:0] drop_count_o;

  int n_checks = 0, n_fail = 0, cyc = 0;

  apple_shadow_write_queue #(.FIFO_DEPTH(8), .BANK_BITS(1), .SHADOW_PAGE_MASK(16'h003D),
                             .MEM_ADDR_WIDTH(21)) dut (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .bus_wr_strobe_i(bus_wr_strobe_i),
    .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_bank_i(bus_bank_i),
    .bus_m2sel_n_i(bus_m2sel_n_i), .shadow_all_i(shadow_all_i), .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_ready_i(mem_ready_i), .fifo_level_o(fifo_level_o), .overflow_o(overflow_o),
    .drop_count_o(drop_count_o));

  always #5 clk_logic = ~clk_logic;
  always @(posedge clk_logic) cyc <= cyc + 1;

  typedef struct { logic [20:0] addr; logic [31:0] data; logic [3:0] be; int c; } req_t;
  req_t       got[$];
  logic [7:0] dut_img[int];
  logic [7:0] model_img[int];

  // Inputs change only just after posedge, so a handshake seen here completes at the next edge.
  always @(negedge clk_logic) begin
    if (system_reset_n && mem_wr_o && mem_ready_i) begin
      got.push_back('{mem_addr_o, mem_data_o, mem_byte_en_o, cyc});
      for (int l = 0; l < 4; l++)
        if (mem_byte_en_o[l]) dut_img[int'(mem_addr_o) * 4 + l] = mem_data_o[l*8 +: 8];
    end
  end

  function automatic logic [20:0] m_word(input logic [15:0] a);
    return 21'(a >> 1);
  endfunction
  function automatic int m_lane(input logic [15:0] a, input logic b);
    return int'(a[0]) * 2 + int'(b);
  endfunction

  task automatic tick;
    @(posedge clk_logic); #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic b);
    bus_addr_i = a; bus_data_i = d; bus_bank_i = b; bus_wr_strobe_i = 1;
    tick;
    bus_wr_strobe_i = 0;
  endtask

  task automatic test_reset;
    system_reset_n = 0;
    repeat (2) tick;
    n_checks++; if (mem_wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %0b want 0", mem_wr_o); end
    n_checks++; if (mem_addr_o !== 21'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
    n_checks++; if (mem_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", mem_data_o); end
    n_checks++; if (mem_byte_en_o !== 4'h0) begin n_fail++; $display("FAIL reset_be got %b want 0", mem_byte_en_o); end
    n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow_o); end
    n_checks++; if (drop_count_o !== 16'h0) begin n_fail++; $display("FAIL reset_drops got %0d want 0", drop_count_o); end
    system_reset_n = 1;
    tick;
  endtask

  task automatic test_single(input string tag);
    mem_ready_i = 1; got.delete();
    do_write(16'h0401, 8'hA5, 1'b0);
    n_checks++; if (mem_wr_o !== 1'b0 || fifo_level_o !== 4'd1) begin n_fail++;
      $display("FAIL %s_n1 got wr=%0b lvl=%0d want wr=0 lvl=1", tag, mem_wr_o, fifo_level_o); end
    tick;
    n_checks++; if (mem_wr_o !== 1'b1) begin n_fail++; $display("FAIL %s_wr got %0b want 1", tag, mem_wr_o); end
    n_checks++; if (mem_addr_o !== 21'h000200) begin n_fail++; $display("FAIL %s_addr got %h want 000200", tag, mem_addr_o); end
    n_checks++; if (mem_data_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL %s_data got %h want a5a5a5a5", tag, mem_data_o); end
    n_checks++; if (mem_byte_en_o !== 4'b0100) begin n_fail++; $display("FAIL %s_be got %b want 0100", tag, mem_byte_en_o); end
    tick;
    n_checks++; if (mem_wr_o !== 1'b0) begin n_fail++; $display("FAIL %s_one_cycle got wr=%0b want 0", tag, mem_wr_o); end
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL %s_count got %0d want 1", tag, got.size()); end
  endtask

  task automatic test_masking;
    mem_ready_i = 1; got.delete(); shadow_all_i = 0;
    do_write(16'h1000, 8'h01, 1'b0);
    do_write(16'h6000, 8'h02, 1'b0);
    bus_m2sel_n_i = 1;
    do_write(16'h2000, 8'h03, 1'b0);
    bus_m2sel_n_i = 0;
    repeat (4) tick;
    n_checks++; if (got.size() != 0 || fifo_level_o !== 4'd0) begin n_fail++;
      $display("FAIL mask_blocked got reqs=%0d lvl=%0d want 0/0", got.size(), fifo_level_o); end
    shadow_all_i = 1;
    do_write(16'h6000, 8'h04, 1'b0);
    shadow_all_i = 0;
    repeat (3) tick;
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL mask_all_count got %0d want 1", got.size()); end
    else begin
      n_checks++; if (got[0].addr !== 21'h003000) begin n_fail++; $display("FAIL mask_all_addr got %h want 003000", got[0].addr); end
    end
  endtask

  task automatic test_coalesce;
    int t;
    mem_ready_i = 0; got.delete();
    do_write(16'h2000, 8'h11, 1'b0);
    do_write(16'h2000, 8'h22, 1'b1);
    do_write(16'h2001, 8'h33, 1'b0);
    n_checks++; if (mem_wr_o !== 1'b1 || mem_addr_o !== 21'h001000 || mem_byte_en_o !== 4'b0001) begin n_fail++;
      $display("FAIL coal_issue got wr=%0b addr=%h be=%b want 1/001000/0001", mem_wr_o, mem_addr_o, mem_byte_en_o); end
    n_checks++; if (fifo_level_o !== 4'd1) begin n_fail++; $display("FAIL coal_level got %0d want 1", fifo_level_o); end
    mem_ready_i = 1;
    t = 0;
    while (got.size() < 2 && t < 20) begin tick; t++; end
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL coal_timeout got %0d reqs want 2", got.size()); end
    else begin
      n_checks++; if (got[1].addr !== 21'h001000 || got[1].be !== 4'b0110) begin n_fail++;
        $display("FAIL coal_merge got addr=%h be=%b want 001000/0110", got[1].addr, got[1].be); end
      n_checks++; if (got[1].data[15:8] !== 8'h22 || got[1].data[23:16] !== 8'h33) begin n_fail++;
        $display("FAIL coal_data got %h want lane1=22 lane2=33", got[1].data); end
    end
    repeat (2) tick;
  endtask

  req_t exp_q[$];

  task automatic test_overflow;
    logic [15:0] a;
    mem_ready_i = 0; got.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      a = 16'h3000 + 16'(2 * i);
      if (i < 9) exp_q.push_back('{m_word(a), {4{8'(8'h40 + i)}}, 4'(1 << m_lane(a, 1'b0)), 0});
      do_write(a, 8'(8'h40 + i), 1'b0);
    end
    n_checks++; if (fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", fifo_level_o); end
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow_o); end
    n_checks++; if (drop_count_o !== 16'd1) begin n_fail++; $display("FAIL ovf_drops got %0d want 1", drop_count_o); end
    n_checks++; if (mem_wr_o !== 1'b1 || mem_addr_o !== exp_q[0].addr) begin n_fail++;
      $display("FAIL ovf_outreg got wr=%0b addr=%h want 1/%h", mem_wr_o, mem_addr_o, exp_q[0].addr); end
  endtask

  task automatic test_full_pop;
    int t;
    logic [15:0] a;
    a = 16'h3100;
    exp_q.push_back('{m_word(a), {4{8'h7E}}, 4'(1 << m_lane(a, 1'b1)), 0});
    mem_ready_i = 1;
    do_write(a, 8'h7E, 1'b1);
    n_checks++; if (fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL fullpop_level got %0d want 8", fifo_level_o); end
    n_checks++; if (drop_count_o !== 16'd1) begin n_fail++; $display("FAIL fullpop_drops got %0d want 1", drop_count_o); end
    t = 0;
    while (got.size() < exp_q.size() && t < 40) begin tick; t++; end
    n_checks++; if (got.size() != exp_q.size()) begin n_fail++;
      $display("FAIL drain_count got %0d want %0d", got.size(), exp_q.size()); end
    else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data || got[i].be !== exp_q[i].be ||
            got[i].c != got[0].c + i) begin n_fail++;
          $display("FAIL drain_%0d got %h/%h/%b@%0d want %h/%h/%b@%0d", i, got[i].addr, got[i].data, got[i].be,
                   got[i].c, exp_q[i].addr, exp_q[i].data, exp_q[i].be, got[0].c + i); end
      end
    tick;
    n_checks++; if (fifo_level_o !== 4'd0 || mem_wr_o !== 1'b0) begin n_fail++;
      $display("FAIL drain_empty got lvl=%0d wr=%0b want 0/0", fifo_level_o, mem_wr_o); end
  endtask

  task automatic test_reset_mid;
    mem_ready_i = 0; got.delete();
    for (int i = 0; i < 6; i++) do_write(16'h4000 + 16'(2 * i), 8'(i), 1'b0);
    n_checks++; if (fifo_level_o !== 4'd5 || mem_wr_o !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_pre got lvl=%0d wr=%0b want 5/1", fifo_level_o, mem_wr_o); end
    #2 system_reset_n = 0;
    #1;
    n_checks++;
    if (mem_wr_o !== 1'b0 || mem_addr_o !== 21'h0 || mem_data_o !== 32'h0 || mem_byte_en_o !== 4'h0 ||
        fifo_level_o !== 4'd0 || overflow_o !== 1'b0 || drop_count_o !== 16'h0) begin n_fail++;
      $display("FAIL rstmid_async got wr=%0b addr=%h data=%h be=%b lvl=%0d ovf=%0b drops=%0d want all 0",
               mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o, fifo_level_o, overflow_o, drop_count_o); end
    tick; tick;
    system_reset_n = 1;
    mem_ready_i = 1;
    repeat (5) tick;
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL rstmid_stale got %0d reqs want 0", got.size()); end
    test_single("rstmid_fresh");
  endtask

  task automatic test_random;
    logic [3:0]  pages[5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6};
    logic [15:0] a;
    logic [7:0]  d;
    logic        b;
    int          t, n;
    dut_img.delete(); model_img.delete();
    for (int burst = 0; burst < 40; burst++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin mem_ready_i = 1'($urandom_range(0, 1)); tick; end
        a = {pages[$urandom_range(0, 4)], 12'($urandom_range(0, 7))};
        d = 8'($urandom);
        b = 1'($urandom_range(0, 1));
        bus_m2sel_n_i = ($urandom_range(0, 7) == 0);
        shadow_all_i  = ($urandom_range(0, 3) == 0);
        mem_ready_i   = 1'($urandom_range(0, 1));
        if (!bus_m2sel_n_i && (shadow_all_i || MASK[a[15:12]]))
          model_img[int'(m_word(a)) * 4 + m_lane(a, b)] = d;
        do_write(a, d, b);
      end
      bus_m2sel_n_i = 0; shadow_all_i = 0;
      t = 0;
      while ((fifo_level_o != 0 || mem_wr_o) && t < 60) begin
        mem_ready_i = 1'($urandom_range(0, 1)); tick; t++;
      end
      if (t == 60) begin n_checks++; n_fail++; $display("FAIL rand_drain_timeout burst %0d lvl=%0d", burst, fifo_level_o); end
    end
    n_checks++; if (dut_img.size() != model_img.size()) begin n_fail++;
      $display("FAIL rand_img_size got %0d want %0d", dut_img.size(), model_img.size()); end
    foreach (model_img[k]) begin
      n_checks++;
      if (!dut_img.exists(k)) begin n_fail++; $display("FAIL rand_img_missing byte %0h want %h", k, model_img[k]); end
      else if (dut_img[k] !== model_img[k]) begin n_fail++;
        $display("FAIL rand_img byte %0h got %h want %h", k, dut_img[k], model_img[k]); end
    end
    n_checks++; if (overflow_o !== 1'b0 || drop_count_o !== 16'd0) begin n_fail++;
      $display("FAIL rand_no_drop got ovf=%0b drops=%0d want 0/0", overflow_o, drop_count_o); end
  endtask

  initial begin
    test_reset;
    test_single("single");
    test_masking;
    test_coalesce;
    test_overflow;
    test_full_pop;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
